// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write-first reads, pending-write scoreboard and observation taps
//
// Purpose:
//   Architectural register file between decode and writeback. Register 0 is
//   hard-wired to zero. Source reads are registered (one cycle latency) and,
//   when BYPASS is set, see a writeback landing on the same edge. A busy bit
//   per register tracks issued-but-not-written-back destinations and drives
//   a combinational RAW stall. A bank of taps mirrors a contiguous window of
//   registers every cycle.
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   LdR, RD, DataR     writeback enable / destination / data
//   IssueV, IssueRd    decode issue of an instruction writing IssueRd
//   RdEn, RS1, RS2     read capture enable and source indices
//   ReadReg1/2         registered source data
//   Stall              combinational RAW hazard on RS1/RS2
//   BusyVec            pending-write bit per register
//   R_IO               registered taps, slice k = register IO_BASE+k

module regfile_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NUM_IO  = 1,
    parameter int IO_BASE = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   LdR,
    input  logic [AW-1:0]          RD,
    input  logic [XLEN-1:0]        DataR,
    input  logic                   IssueV,
    input  logic [AW-1:0]          IssueRd,
    input  logic                   RdEn,
    input  logic [AW-1:0]          RS1,
    input  logic [AW-1:0]          RS2,
    output logic [XLEN-1:0]        ReadReg1,
    output logic [XLEN-1:0]        ReadReg2,
    output logic                   Stall,
    output logic [NREGS-1:0]       BusyVec,
    output logic [NUM_IO*XLEN-1:0] R_IO
);

    // A writeback to idx at this edge is forwarded to readers of idx.
    // Register 0 never forwards, so it keeps reading as zero.
    function automatic logic fwd_hit(
        input logic          ldr,
        input logic [AW-1:0] rd,
        input logic [AW-1:0] idx
    );
        return (BYPASS != 0) && ldr && (rd == idx) && (idx != '0);
    endfunction

    logic [XLEN-1:0]        regs_q [NREGS];
    logic [XLEN-1:0]        rd1_q, rd1_d;
    logic [XLEN-1:0]        rd2_q, rd2_d;
    logic [NUM_IO*XLEN-1:0] tap_q, tap_d;
    logic [NREGS-1:0]       busy_q, busy_d;
    logic [NREGS-1:0]       issue_hot;
    logic [NREGS-1:0]       wb_hot;
    logic [XLEN-1:0]        rs1_val, rs2_val;
    logic                   wr_en;
    logic                   hz1, hz2;

    assign wr_en = LdR && (RD != '0);

    // Storage; entry 0 is never written so it stays zero after reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[RD] <= DataR;
        end
    end

    // Source values as seen at this edge (write-first when BYPASS is set).
    assign rs1_val = fwd_hit(LdR, RD, RS1) ? DataR : regs_q[RS1];
    assign rs2_val = fwd_hit(LdR, RD, RS2) ? DataR : regs_q[RS2];

    assign rd1_d = RdEn ? rs1_val : rd1_q;
    assign rd2_d = RdEn ? rs2_val : rd2_q;

    // Taps follow the same forwarding rule but update every cycle.
    for (genvar k = 0; k < NUM_IO; k++) begin : g_tap
        logic [AW-1:0] idx;
        assign idx = AW'(IO_BASE + k);
        assign tap_d[k*XLEN +: XLEN] = fwd_hit(LdR, RD, idx) ? DataR : regs_q[idx];
    end

    // Scoreboard next state: an issue beats a writeback to the same
    // register because the newly issued producer is still outstanding.
    always_comb begin
        issue_hot = '0;
        wb_hot    = '0;
        if (IssueV) begin
            issue_hot[IssueRd] = 1'b1;
        end
        if (LdR) begin
            wb_hot[RD] = 1'b1;
        end
        busy_d    = (busy_q & ~wb_hot) | issue_hot;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd1_q  <= '0;
            rd2_q  <= '0;
            tap_q  <= '0;
            busy_q <= '0;
        end else begin
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            tap_q  <= tap_d;
            busy_q <= busy_d;
        end
    end

    // A source whose pending write is landing right now is forwarded, so it
    // is not a hazard when bypassing is enabled.
    assign hz1 = busy_q[RS1] && (RS1 != '0) && !fwd_hit(LdR, RD, RS1);
    assign hz2 = busy_q[RS2] && (RS2 != '0) && !fwd_hit(LdR, RD, RS2);

    assign Stall    = hz1 || hz2;
    assign BusyVec  = busy_q;
    assign ReadReg1 = rd1_q;
    assign ReadReg2 = rd2_q;
    assign R_IO     = tap_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb (write-first 32x32 with taps, read-first 8x16)

module tb_regfile_sb;

    localparam int K_A_RR1  = 0;
    localparam int K_A_RR2  = 1;
    localparam int K_A_RIO  = 2;
    localparam int K_A_BUSY = 3;
    localparam int K_B_RR1  = 4;
    localparam int K_B_BUSY = 5;
    localparam int K_B_RIO  = 6;

    typedef struct {
        int           kind;
        string        tag;
        logic [127:0] val;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         a_ldr, a_iv, a_rden, a_stall;
    logic [4:0]   a_rd, a_ird, a_rs1, a_rs2;
    logic [31:0]  a_datar, a_rr1, a_rr2, a_busy;
    logic [127:0] a_rio;

    logic         b_ldr, b_iv, b_rden, b_stall;
    logic [2:0]   b_rd, b_ird, b_rs1, b_rs2;
    logic [15:0]  b_datar, b_rr1, b_rr2, b_rio;
    logic [7:0]   b_busy;

    logic [31:0]  tap [4];

    regfile_sb #(.XLEN(32), .NREGS(32), .NUM_IO(4), .IO_BASE(10), .BYPASS(1)) u_a (
        .CLK(clk), .RST_N(rst_n), .LdR(a_ldr), .RD(a_rd), .DataR(a_datar),
        .IssueV(a_iv), .IssueRd(a_ird), .RdEn(a_rden), .RS1(a_rs1), .RS2(a_rs2),
        .ReadReg1(a_rr1), .ReadReg2(a_rr2), .Stall(a_stall), .BusyVec(a_busy), .R_IO(a_rio)
    );

    regfile_sb #(.XLEN(16), .NREGS(8), .NUM_IO(1), .IO_BASE(1), .BYPASS(0)) u_b (
        .CLK(clk), .RST_N(rst_n), .LdR(b_ldr), .RD(b_rd), .DataR(b_datar),
        .IssueV(b_iv), .IssueRd(b_ird), .RdEn(b_rden), .RS1(b_rs1), .RS2(b_rs2),
        .ReadReg1(b_rr1), .ReadReg2(b_rr2), .Stall(b_stall), .BusyVec(b_busy), .R_IO(b_rio)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input string tag, input logic [127:0] val);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [127:0] got;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_A_RR1:  got = 128'(a_rr1);
                K_A_RR2:  got = 128'(a_rr2);
                K_A_RIO:  got = a_rio;
                K_A_BUSY: got = 128'(a_busy);
                K_B_RR1:  got = 128'(b_rr1);
                K_B_BUSY: got = 128'(b_busy);
                default:  got = 128'(b_rio);
            endcase
            check(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic idle();
        a_ldr = 1'b0; a_iv = 1'b0; a_rden = 1'b0;
        b_ldr = 1'b0; b_iv = 1'b0; b_rden = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        a_rd = '0; a_ird = '0; a_rs1 = '0; a_rs2 = '0; a_datar = '0;
        b_rd = '0; b_ird = '0; b_rs1 = '0; b_rs2 = '0; b_datar = '0;
        for (int k = 0; k < 4; k++) tap[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_rr1", 128'(a_rr1), 128'(0));
        check("rst_a_rr2", 128'(a_rr2), 128'(0));
        check("rst_a_busy", 128'(a_busy), 128'(0));
        check("rst_a_rio", a_rio, 128'(0));
        check("rst_a_stall", 128'(a_stall), 128'(0));
        check("rst_b_rr1", 128'(b_rr1), 128'(0));
        rst_n = 1'b1;

        // x5 written and read in the same cycle, x6 issued
        a_ldr = 1'b1; a_rd = 5'd5; a_datar = 32'hDEADBEEF; a_rs1 = 5'd5; a_rden = 1'b1;
        a_iv = 1'b1; a_ird = 5'd6;
        push(K_A_RR1, "byp_x5", 128'(32'hDEADBEEF));
        push(K_A_BUSY, "busy_x6", 128'(32'h40));
        tick();
        idle(); a_rs2 = 5'd6;
        #1;
        check("stall_x6", 128'(a_stall), 128'(1));

        // mid-run reset clears outputs without a clock edge
        rst_n = 1'b0;
        #1;
        check("arst_rr1", 128'(a_rr1), 128'(0));
        check("arst_busy", 128'(a_busy), 128'(0));
        check("arst_stall", 128'(a_stall), 128'(0));
        check("arst_rio", a_rio, 128'(0));
        a_ldr = 1'b1; a_rd = 5'd5; a_datar = 32'h55555555; a_iv = 1'b1; a_ird = 5'd7;
        tick();
        tick();
        idle(); rst_n = 1'b1;
        a_rs1 = 5'd5; a_rden = 1'b1;
        push(K_A_RR1, "x5_after_rst", 128'(0));
        push(K_A_BUSY, "busy_after_rst", 128'(0));
        tick();

        // writes to x0 are ignored
        a_ldr = 1'b1; a_rd = 5'd0; a_datar = 32'h1234; a_rs1 = 5'd0; a_rden = 1'b1;
        push(K_A_RR1, "x0_same", 128'(0));
        tick();
        a_ldr = 1'b0;
        push(K_A_RR1, "x0_after", 128'(0));
        tick();

        // write-first (A) vs read-first (B) on x7
        a_ldr = 1'b1; a_rd = 5'd7; a_datar = 32'h0BAD0001; a_rden = 1'b0;
        b_ldr = 1'b1; b_rd = 3'd7; b_datar = 16'h0BAD;
        tick();
        a_datar = 32'hA5A5A5A5; a_rs1 = 5'd7; a_rden = 1'b1;
        b_datar = 16'hA5A5; b_rs1 = 3'd7; b_rden = 1'b1;
        push(K_A_RR1, "wf_x7", 128'(32'hA5A5A5A5));
        push(K_B_RR1, "rf_x7_old", 128'(16'h0BAD));
        tick();
        idle(); b_rden = 1'b1;
        push(K_B_RR1, "rf_x7_new", 128'(16'hA5A5));
        tick();

        // RdEn hold
        idle();
        a_ldr = 1'b1; a_rd = 5'd3; a_datar = 32'h11;
        tick();
        a_rd = 5'd4; a_datar = 32'h22; a_rs1 = 5'd3; a_rden = 1'b1;
        push(K_A_RR1, "hold_x3", 128'(32'h11));
        tick();
        idle(); a_rs1 = 5'd4;
        push(K_A_RR1, "hold_keep", 128'(32'h11));
        tick();
        a_rden = 1'b1;
        push(K_A_RR1, "hold_new", 128'(32'h22));
        tick();

        // scoreboard on x9
        idle(); a_iv = 1'b1; a_ird = 5'd9;
        push(K_A_BUSY, "issue_x9", 128'(32'h200));
        tick();
        idle(); a_rs1 = 5'd0; a_rs2 = 5'd9;
        #1;
        check("stall_x9", 128'(a_stall), 128'(1));
        a_ldr = 1'b1; a_rd = 5'd8; a_datar = 32'h88;
        #1;
        check("stall_wb_other", 128'(a_stall), 128'(1));
        a_rd = 5'd9; a_datar = 32'h99;
        #1;
        check("stall_wb_mask", 128'(a_stall), 128'(0));
        a_rden = 1'b1;
        push(K_A_RR2, "rr2_x9_fwd", 128'(32'h99));
        push(K_A_BUSY, "clr_x9", 128'(0));
        tick();
        idle();
        #1;
        check("stall_after_clr", 128'(a_stall), 128'(0));
        a_iv = 1'b1; a_ird = 5'd9;
        push(K_A_BUSY, "reissue_x9", 128'(32'h200));
        tick();
        a_ldr = 1'b1; a_rd = 5'd9; a_datar = 32'h9A;
        push(K_A_BUSY, "issue_wb_same", 128'(32'h200));
        tick();
        idle(); a_iv = 1'b1; a_ird = 5'd0;
        push(K_A_BUSY, "issue_x0_a", 128'(32'h200));
        tick();
        idle(); a_ldr = 1'b1; a_rd = 5'd9; a_datar = 32'h9B;
        push(K_A_BUSY, "final_clr_x9", 128'(0));
        tick();

        // taps x10..x13, independent of RdEn
        for (int k = 0; k < 4; k++) begin
            idle();
            a_ldr = 1'b1; a_rd = 5'(10 + k); a_datar = 32'(k + 1); a_rden = (k % 2 == 1);
            tap[k] = 32'(k + 1);
            push(K_A_RIO, $sformatf("tap_w%0d", k), {tap[3], tap[2], tap[1], tap[0]});
            tick();
        end
        idle();
        push(K_A_RIO, "tap_hold", {32'd4, 32'd3, 32'd2, 32'd1});
        tick();

        // generic sizing on B
        b_ldr = 1'b1; b_rd = 3'd7; b_datar = 16'hFFFF;
        tick();
        idle(); b_rs1 = 3'd7; b_rden = 1'b1;
        push(K_B_RR1, "b_x7", 128'(16'hFFFF));
        tick();
        idle(); b_iv = 1'b1; b_ird = 3'd0;
        push(K_B_BUSY, "b_issue_x0", 128'(0));
        tick();

        // read-first taps lag a write by one extra edge
        idle(); b_ldr = 1'b1; b_rd = 3'd1; b_datar = 16'h1357;
        push(K_B_RIO, "b_tap_old", 128'(0));
        tick();
        idle();
        push(K_B_RIO, "b_tap_new", 128'(16'h1357));
        tick();

        // read-first: no stall masking on writeback
        b_iv = 1'b1; b_ird = 3'd3;
        push(K_B_BUSY, "b_issue_x3", 128'(8'h08));
        tick();
        idle(); b_rs1 = 3'd3; b_ldr = 1'b1; b_rd = 3'd3; b_datar = 16'h1;
        #1;
        check("b_stall_nomask", 128'(b_stall), 128'(1));
        push(K_B_BUSY, "b_clr_x3", 128'(0));
        tick();
        idle();
        #1;
        check("b_stall_clr", 128'(b_stall), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with registered, write-first read ports, per-register pending-write scoreboard and a configurable bank of observation taps. It sits between decode (source reads, destination issue) and writeback in the LittleRISC-V core. It replaces the fixed 32x32 file and generalises width, depth and tap count. It adds asynchronous reset, read enable, bypass and RAW-hazard stall generation.

## Interface
- XLEN, 32, data width in bits (>= 8)
- NREGS, 32, number of architectural registers; power of two, >= 4
- AW, $clog2(NREGS), address width; derived, never overridden
- NUM_IO, 1, number of observation taps, 1..NREGS-1
- IO_BASE, 1, first register index mirrored on the taps; IO_BASE+NUM_IO <= NREGS
- BYPASS, 1, 1 = write-first reads and writeback-aware stall; 0 = read-first reads
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- LdR  in  1  writeback enable
- RD  in  AW  writeback destination index
- DataR  in  XLEN  writeback data
- IssueV  in  1  decode issues an instruction that will write IssueRd
- IssueRd  in  AW  destination of the issuing instruction
- RdEn  in  1  capture new read data this cycle
- RS1, RS2  in  AW  source indices
- ReadReg1, ReadReg2  out  XLEN  registered source data
- Stall  out  1  combinational RAW hazard on RS1/RS2
- BusyVec  out  NREGS  pending-write bit per register
- R_IO  out  NUM_IO*XLEN  registered taps; slice k = register IO_BASE+k

## Operation
- Storage: NREGS x XLEN. Register 0 reads as 0 at all times. Writes and issues targeting index 0 are ignored.
- Write: on a rising edge with LdR=1 and RD!=0, REG[RD] <= DataR.
- Read: on a rising edge with RdEn=1, ReadReg1 <= value(RS1) and ReadReg2 <= value(RS2). With RdEn=0, both outputs hold.
  - With BYPASS=1, value(x) = DataR when LdR=1 and RD==x!=0; otherwise value(x) = REG[x] (write-first).
  - With BYPASS=0, value(x) = REG[x] before the edge (read-first).
- Taps: every rising edge, R_IO slice k <= value(IO_BASE+k), using the same bypass rule. Taps ignore RdEn.
- Scoreboard, per register r != 0, at each rising edge:
  - busy set when IssueV=1 and IssueRd==r;
  - else busy cleared when LdR=1 and RD==r;
  - else busy holds.
  - Simultaneous issue and writeback to the same r leaves busy=1 (new producer wins).
  - busy[0] is constantly 0. BusyVec exposes busy directly.
- Stall = hz(RS1) | hz(RS2), combinational, where hz(x) = busy[x] & (x!=0).
  - With BYPASS=1, hz(x) is additionally masked when LdR=1 and RD==x, because that writeback is forwarded at this edge.
- Out-of-range parameters are a configuration error. The block does not need to handle them.

## Timing
- Reset: while RST_N=0, all registers are 0, all busy bits are 0, ReadReg1/2 are 0 and R_IO is all 0. Stall and BusyVec are therefore 0. Assertion is immediate, with no clock required. Deassertion is synchronised externally by the core.
- Reset asserted mid-operation discards any in-flight writeback and issue in that cycle. No partial update is allowed.
- Read latency: 1 cycle. RS presented in cycle n gives data on ReadReg in cycle n+1, reflecting any write at the edge ending cycle n when BYPASS=1.
- Write-to-tap latency: 1 edge.
- Issue-to-busy: busy is visible on BusyVec/Stall in the cycle after IssueV. Writeback-to-clear behaves the same way.
- Stall has no registered state of its own; it is valid in the same cycle as RS1/RS2/LdR/RD.

## Test plan
- Reset and zero register:
  - assert RST_N=0 mid-run after writing x5=0xDEADBEEF -> all outputs 0 without a clock edge, and x5 reads 0 after release;
  - LdR with RD=0, DataR=0x1234 -> RS1=0 reads 0.
- Write-first bypass (BYPASS=1):
  - same cycle: LdR, RD=7, DataR=0xA5A5A5A5, RS1=7, RdEn=1 -> ReadReg1=0xA5A5A5A5 next cycle;
  - with BYPASS=0 -> the old value is returned instead.
- RdEn hold: read x3=0x11, then change RS1=4 (x4=0x22) with RdEn=0 -> ReadReg1 stays 0x11; raise RdEn -> 0x22.
- Scoreboard:
  - IssueV with IssueRd=9 -> BusyVec[9]=1 next cycle, and RS2=9 gives Stall=1;
  - LdR, RD=9 in a later cycle -> Stall=0 in that same cycle (BYPASS=1) and BusyVec[9]=0 after the edge;
  - simultaneous IssueRd=9 and RD=9 -> busy stays 1.
- Taps (NUM_IO=4, IO_BASE=10): write x10..x13 = 1..4 -> R_IO = {4,3,2,1} one edge after each write, regardless of RdEn.
- Generic sizing (XLEN=16, NREGS=8): write x7=0xFFFF, read x7 -> 0xFFFF; issue x0 -> BusyVec=0.
